x_regfile_mp: RTL
=================

Name: x_regfile_mp

Overview:
- Parametrised multi-port integer register file for the core.
- Successor to the fixed 3-read/1-write x-register file: configurable width, depth, read-port count and write-port count.
- Adds a per-register busy scoreboard with an allocate handshake, so decode can stall on RAW/WAW hazards.
- Sits between decode (reads, allocate) and writeback (writes).

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of registers (power of two, ≥ 2).
- NRD, 3, number of read ports.
- NWR, 2, number of write ports.
- ZERO_REG, 1, when 1, register 0 reads 0, ignores writes and is never busy.

Ports:
- iCLK  in  1  core clock, rising edge.
- iRST_N  in  1  reset, asynchronous, active-low; clears all registers and busy bits.
- iRS_ADDR  in  NRD*AW  packed read addresses; AW = clog2(NREG); port k is bits [k*AW +: AW].
- oRS_DATA  out  NRD*XLEN  packed read data, combinational.
- oRS_BUSY  out  NRD  busy bit of each addressed register.
- iWE  in  NWR  write enables.
- iWADDR  in  NWR*AW  packed write addresses.
- iWDATA  in  NWR*XLEN  packed write data.
- iALLOC_VALID  in  1  request to mark the destination register pending.
- iALLOC_ADDR  in  AW  destination register to allocate.
- oALLOC_READY  out  1  allocate accepted this cycle.

Behaviour:
- Reset (iRST_N=0, any time, asynchronous):
  - All registers = 0, all busy bits = 0.
  - Outputs during reset: oRS_DATA = 0, oRS_BUSY = 0, oALLOC_READY = 0.
  - A write or allocate in progress when reset asserts is lost.
- Read:
  - Combinational from array state: oRS_DATA[k] = reg[iRS_ADDR[k]].
  - A write is visible on the read ports the cycle after the iCLK edge that commits it.
- Write:
  - On the iCLK rising edge, each port j with iWE[j]=1 writes iWDATA[j] to iWADDR[j].
  - Same-address conflict: the highest-index port wins (port NWR-1 has top priority).
  - A write clears the target's busy bit, unless an allocate to the same address is accepted in the same cycle; allocate wins and busy stays 1.
  - A write to a non-busy register is legal; busy stays 0.
- Allocate handshake:
  - oALLOC_READY = iRST_N & ~busy[iALLOC_ADDR].
  - ZERO_REG=1 and iALLOC_ADDR=0: ready=1, no effect.
  - Transfer occurs when iALLOC_VALID & oALLOC_READY; busy[iALLOC_ADDR] is set at that edge.
  - Busy target gives ready=0 (WAW stall). The requester holds VALID and ADDR stable until ready.
  - ready depends only on registered busy state, never on same-cycle writes, so there is no combinational loop from writeback to decode.
- Busy output: oRS_BUSY[k] = busy[iRS_ADDR[k]]; with ZERO_REG=1, address 0 always reads 0.
- Register 0 (ZERO_REG=1): reads 0; writes are discarded.
- Reset values use no initial blocks; reset is the only initialisation mechanism.

Optional Feature:
- Macro: XRF_BYPASS_EN.
- Defined:
  - A read port whose address matches an enabled write port in the same cycle returns that write's data combinationally (highest-index matching port wins).
  - The matching oRS_BUSY bit reads 0 in that cycle.
  - Zero-reg reads are never bypassed.
  - Read-after-write latency is 0 cycles.
- Undefined:
  - No forwarding; new data and the cleared busy bit appear the next cycle.
  - Read-after-write latency is 1 cycle.

Decomposition:
- Package xrf_pkg:
  - XLEN_DEF and NREG_DEF constants.
  - Address-width function clog2.
  - reg_addr_t typedef.
- Sub-module xrf_scoreboard:
  - Holds the NREG busy-bit vector, allocate handshake, and write-clear logic with allocate-wins priority.
  - Exposes the busy vector to the top level, which performs read-port lookup and bypass.
- Top level holds the data array, write arbitration and read muxing.

Test Plan:
- Reset clear: write 0xDEADBEEF to x5, pulse iRST_N low mid-cycle → oRS_DATA for x5 = 0 immediately, oRS_BUSY = 0, oALLOC_READY = 0 while low.
- Port conflict: iWE=2'b11, both ports address x7, data 0x11 on port 0 and 0x22 on port 1 → next cycle x7 reads 0x22.
- Zero register: write 0x1234 to x0 and allocate x0 → x0 reads 0, busy 0, oALLOC_READY = 1.
- Scoreboard: allocate x3 → cycle+1 busy=1; second allocate x3 → ready=0 until port 0 writes 0x55 to x3; busy clears next cycle, ready returns 1.
- Allocate-wins: same cycle, write x4 and accepted allocate x4 → busy[x4] stays 1, x4 data updated.
- Bypass (XRF_BYPASS_EN): read x9 while port 1 writes 0xCAFE to x9 → same-cycle oRS_DATA = 0xCAFE, busy 0; without the macro → old value, then 0xCAFE one cycle later.

Source files
------------

// File: rtl/xrf_pkg.sv
`default_nettype none
// ============================================================================
// Package     : xrf_pkg
// Description : Shared defaults, address-width helper and register address type
//               for the multi-port integer register file.
// Revision    : 1.0 - initial release
// ============================================================================
package xrf_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    // Smallest r with 2**r >= n; callers guarantee n >= 2
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    typedef logic [clog2(NREG_DEF)-1:0] reg_addr_t;

endpackage : xrf_pkg
`default_nettype wire

// File: rtl/x_regfile_mp_if.sv
`default_nettype none
// ============================================================================
// Interface   : x_regfile_mp_if
// Description : Read, write and allocate bus between decode/writeback and the
//               multi-port register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface x_regfile_mp_if
    import xrf_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRD  = 3,
    parameter int NWR  = 2
);
    localparam int AW = clog2(NREG);

    logic [NRD*AW-1:0]    iRS_ADDR;
    logic [NRD*XLEN-1:0]  oRS_DATA;
    logic [NRD-1:0]       oRS_BUSY;
    logic [NWR-1:0]       iWE;
    logic [NWR*AW-1:0]    iWADDR;
    logic [NWR*XLEN-1:0]  iWDATA;
    logic                 iALLOC_VALID;
    logic [AW-1:0]        iALLOC_ADDR;
    logic                 oALLOC_READY;

    modport master (
        output iRS_ADDR, iWE, iWADDR, iWDATA, iALLOC_VALID, iALLOC_ADDR,
        input  oRS_DATA, oRS_BUSY, oALLOC_READY
    );

    modport slave (
        input  iRS_ADDR, iWE, iWADDR, iWDATA, iALLOC_VALID, iALLOC_ADDR,
        output oRS_DATA, oRS_BUSY, oALLOC_READY
    );

endinterface : x_regfile_mp_if
`default_nettype wire

// File: rtl/xrf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : xrf_scoreboard
// Description : Per-register busy bits with allocate handshake; writes clear,
//               an accepted allocate sets and wins over a same-cycle write.
// Revision    : 1.0 - initial release
// ============================================================================
module xrf_scoreboard #(
    parameter int NREG     = 32,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int AW       = 5
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic [NWR-1:0]    i_we,
    input  wire logic [NWR*AW-1:0] i_waddr,
    input  wire logic              i_alloc_valid,
    input  wire logic [AW-1:0]     i_alloc_addr,
    output      logic              o_alloc_ready,
    output      logic [NREG-1:0]   o_busy
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;
    logic            w_alloc_fire;

    // Ready looks only at registered state so writeback never loops into decode
    assign o_alloc_ready = rst_n & ~r_busy[i_alloc_addr];
    assign w_alloc_fire  = i_alloc_valid & o_alloc_ready;
    assign o_busy        = r_busy;

    always_comb begin
        w_busy_nxt = r_busy;
        for (int j = 0; j < NWR; j++) begin
            if (i_we[j]) w_busy_nxt[i_waddr[j*AW +: AW]] = 1'b0;
        end
        if (w_alloc_fire) w_busy_nxt[i_alloc_addr] = 1'b1;
        if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_busy <= '0;
        else        r_busy <= w_busy_nxt;
    end

endmodule : xrf_scoreboard
`default_nettype wire

// File: rtl/x_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : x_regfile_mp
// Description : Parametrised NRD-read / NWR-write integer register file with
//               busy scoreboard. Define XRF_BYPASS_EN for same-cycle forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module x_regfile_mp
    import xrf_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREG     = NREG_DEF,
    parameter int NRD      = 3,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1
) (
    input  wire logic iCLK,
    input  wire logic iRST_N,
    x_regfile_mp_if.slave bus
);

    localparam int AW = clog2(NREG);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] w_busy;
    logic [AW-1:0]   w_waddr [NWR];
    logic [XLEN-1:0] w_wdata [NWR];

    xrf_scoreboard #(
        .NREG     (NREG),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_scoreboard (
        .clk           (iCLK),
        .rst_n         (iRST_N),
        .i_we          (bus.iWE),
        .i_waddr       (bus.iWADDR),
        .i_alloc_valid (bus.iALLOC_VALID),
        .i_alloc_addr  (bus.iALLOC_ADDR),
        .o_alloc_ready (bus.oALLOC_READY),
        .o_busy        (w_busy)
    );

    for (genvar j = 0; j < NWR; j++) begin : g_wr
        assign w_waddr[j] = bus.iWADDR[j*AW +: AW];
        assign w_wdata[j] = bus.iWDATA[j*XLEN +: XLEN];
    end

    // Later ports overwrite earlier ones, giving port NWR-1 top priority
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int r = 0; r < NREG; r++) r_regs[r] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (bus.iWE[j] && !((ZERO_REG != 0) && (w_waddr[j] == '0)))
                    r_regs[w_waddr[j]] <= w_wdata[j];
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   w_addr;
        logic [XLEN-1:0] w_data;
        logic            w_rbusy;
        logic            w_is_zero;

        assign w_addr    = bus.iRS_ADDR[k*AW +: AW];
        assign w_is_zero = (ZERO_REG != 0) && (w_addr == '0);

        always_comb begin
            w_data  = r_regs[w_addr];
            w_rbusy = w_busy[w_addr];
`ifdef XRF_BYPASS_EN
            for (int j = 0; j < NWR; j++) begin
                if (bus.iWE[j] && (w_waddr[j] == w_addr)) begin
                    w_data  = w_wdata[j];
                    w_rbusy = 1'b0;
                end
            end
`endif
            if (w_is_zero || !iRST_N) begin
                w_data  = '0;
                w_rbusy = 1'b0;
            end
        end

        assign bus.oRS_DATA[k*XLEN +: XLEN] = w_data;
        assign bus.oRS_BUSY[k]              = w_rbusy;
    end

endmodule : x_regfile_mp
`default_nettype wire
